inv_arbiter: RTL and testbench

//  - Shares one modular-inverse unit (inv) between NREQ requesters. All requesters use the same modulus P.
//  - Arbitration is round-robin. The block latches the winning operand, pulses the inverter start, and waits for done.
//  - The result is returned to the granted requester on a one-cycle response strobe.
//  - Sits between the point-arithmetic controllers and the single shared inv instance.

---
 rtl/inv_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_inv_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_arbiter.sv
// inv_arbiter: round-robin arbiter sharing one modular-inverse unit among
// NREQ requesters. A winning operand is latched, the inverter is started,
// and its result is returned to the granted requester on a one-cycle strobe.
// Zero operands bypass the inverter and are answered with rsp_err=1.
// Optional macro INV_ARB_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles; without it WAIT lasts until inv_done.
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid[i] && req_ready[i]. req_ready is only offered in IDLE, is
// one-hot, and lasts one cycle; a requester may drop req_valid at any time
// before that edge to withdraw. Responses have no backpressure.
module inv_arbiter #(
    parameter int WIDTH          = 256,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    output logic [NREQ-1:0]       req_ready,
    output logic                  inv_start,
    output logic [WIDTH-1:0]      inv_a,
    input  logic                  inv_done,
    input  logic [WIDTH:0]        inv_result,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH:0]        rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [WIDTH:0]    res_q, res_d;
    logic              inv_start_q, inv_start_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     gsel;
    logic [WIDTH-1:0]  op_sel;

`ifdef INV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] timeout_cycles_unused;
    assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
`endif

    // Round-robin search: first set request bit above the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
                    found = 1'b1;
                    gsel  = PW'(i);
                end
            end
        end
    end

    // Operand of the candidate winner.
    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gsel == PW'(i)) begin
                op_sel = req_a[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept pulse is offered only while idle and never during reset.
    assign req_ready = (state_q == S_IDLE && reset_n && found) ? (ONE_HOT0 << gsel) : '0;

    // Next-state and next-output logic of the job FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        res_d       = res_q;
        inv_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
`ifdef INV_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d = gsel;
                    op_d  = op_sel;
                    if (op_sel == '0) begin
                        // Zero has no inverse: answer immediately with an error.
                        res_d       = '0;
                        rsp_valid_d = ONE_HOT0 << gsel;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        inv_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef INV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (inv_done) begin
                    res_d       = inv_result;
                    rsp_valid_d = ONE_HOT0 << gnt_q;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end
`ifdef INV_ARB_TIMEOUT_EN
                else if (timeout) begin
                    res_d       = '0;
                    rsp_valid_d = ONE_HOT0 << gnt_q;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RESP: begin
                ptr_d   = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            gnt_q       <= '0;
            op_q        <= '0;
            res_q       <= '0;
            inv_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            res_q       <= res_d;
            inv_start_q <= inv_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
`ifdef INV_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign inv_start = inv_start_q;
    assign inv_a     = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_arbiter.sv
// Bench for inv_arbiter (WIDTH=8, NREQ=4, P=13). Contains an inverter model
// answering a^-1 mod P 20 cycles after inv_start, a negedge monitor that logs
// accepts/starts/responses with cycle stamps, and scenario tasks that compare
// those logs with a round-robin/inverse reference model.
module tb_inv_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int TOUT  = 16;
    localparam int P     = 13;
    localparam int LAT   = 20;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ-1:0]       req_ready;
    logic                  inv_start;
    logic [WIDTH-1:0]      inv_a;
    logic                  inv_done;
    logic [WIDTH:0]        inv_result;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH:0]        rsp_data;
    logic                  rsp_err;
    logic                  busy;

    inv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a),
        .req_ready(req_ready), .inv_start(inv_start), .inv_a(inv_a),
        .inv_done(inv_done), .inv_result(inv_result), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int mdl_last = NREQ - 1;

    // ---------------- reference model ----------------
    function automatic logic [WIDTH:0] inv_ref(input logic [WIDTH-1:0] a);
        int r;
        r = int'(a) % P;
        for (int x = 1; x < P; x++) begin
            if ((r * x) % P == 1) return (WIDTH+1)'(x);
        end
        return '0;
    endfunction

    function automatic int rr_next(input int last, input logic [NREQ-1:0] pend);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        int v;
        if ($urandom_range(0, 3) == 0) return '0;
        do v = $urandom_range(1, 255); while (v % P == 0);
        return WIDTH'(v);
    endfunction

    // ---------------- inverter model ----------------
    int               pend_cyc = -1;
    logic [WIDTH-1:0] pend_a;
    bit               mute = 1'b0;

    initial begin
        inv_done   = 1'b0;
        inv_result = '0;
        forever begin
            @(posedge clk);
            #1;
            inv_done = 1'b0;
            if (pend_cyc >= 0 && cyc == pend_cyc + LAT) begin
                inv_done   = 1'b1;
                inv_result = inv_ref(pend_a);
                pend_cyc   = -1;
            end
            if (inv_start === 1'b1 && !mute) begin
                pend_cyc = cyc;
                pend_a   = inv_a;
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct { int c; logic [NREQ-1:0] vec; } acc_t;
    typedef struct { int c; logic [WIDTH-1:0] a; } start_t;
    typedef struct { int c; logic [NREQ-1:0] vec; logic [WIDTH:0] data; logic err; } rsp_t;

    acc_t   acc_log[$];
    start_t start_log[$];
    rsp_t   rsp_log[$];

    always @(negedge clk) begin
        if (req_ready != '0) acc_log.push_back('{cyc, req_ready});
        if (inv_start === 1'b1) start_log.push_back('{cyc, inv_a});
        if (rsp_valid != '0) rsp_log.push_back('{cyc, rsp_valid, rsp_data, rsp_err});
    end

    task automatic clear_logs();
        acc_log.delete();
        start_log.delete();
        rsp_log.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Requesters in mask raise req_valid; without sticky each drops its bit
    // after its own accept. Returns after n_acc accepts or a cycle budget.
    task automatic drive_reqs(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] ops,
                              input bit sticky, input int n_acc, output bit ok);
        int seen = 0;
        int guard = 0;
        logic [NREQ-1:0] live = mask;
        @(posedge clk);
        #1;
        req_a     = ops;
        req_valid = live;
        while (seen < n_acc && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (req_ready != '0) begin
                seen++;
                if (!sticky) live &= ~req_ready;
            end
            @(posedge clk);
            #1;
            if (seen >= n_acc) live = '0;
            req_valid = live;
        end
        req_valid = '0;
        ok = (seen >= n_acc);
    endtask

    task automatic wait_idle(output bit ok);
        int g = 0;
        @(negedge clk);
        while (busy !== 1'b0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        ok = (busy === 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // Drives one batch and checks every job against the reference model.
    task automatic run_batch(input string name, input logic [NREQ-1:0] mask,
                             input logic [NREQ*WIDTH-1:0] ops, input bit sticky, input int n_acc);
        bit ok;
        int si = 0;
        int ei;
        logic [NREQ-1:0] pend = mask;
        logic [NREQ-1:0] oh;
        logic [WIDTH-1:0] a_exp;
        clear_logs();
        drive_reqs(mask, ops, sticky, n_acc, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s accept_budget: accepts=%0d need=%0d", name, acc_log.size(), n_acc); end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s idle_budget: busy=%b need=0", name, busy); end
        n_cmp++;
        if (acc_log.size() != n_acc || rsp_log.size() != n_acc) begin
            n_err++;
            $display("FAIL %s job_count: accepts=%0d rsps=%0d need=%0d", name, acc_log.size(), rsp_log.size(), n_acc);
            return;
        end
        for (int j = 0; j < n_acc; j++) begin
            ei = rr_next(mdl_last, pend);
            if (ei < 0) ei = 0;
            oh = NREQ'(1) << ei;
            mdl_last = ei;
            if (!sticky) pend[ei] = 1'b0;
            a_exp = ops[ei*WIDTH +: WIDTH];
            n_cmp++;
            if (acc_log[j].vec !== oh) begin n_err++; $display("FAIL %s grant[%0d]: got %b need %b", name, j, acc_log[j].vec, oh); end
            n_cmp++;
            if (rsp_log[j].vec !== oh) begin n_err++; $display("FAIL %s rsp_vec[%0d]: got %b need %b", name, j, rsp_log[j].vec, oh); end
            if (a_exp == '0) begin
                n_cmp++;
                if (rsp_log[j].c != acc_log[j].c + 1) begin n_err++; $display("FAIL %s zero_lat[%0d]: got %0d need %0d", name, j, rsp_log[j].c, acc_log[j].c + 1); end
                n_cmp++;
                if (rsp_log[j].data !== '0 || rsp_log[j].err !== 1'b1) begin n_err++; $display("FAIL %s zero_rsp[%0d]: got data=%0d err=%b need 0/1", name, j, rsp_log[j].data, rsp_log[j].err); end
            end else begin
                n_cmp++;
                if (si >= start_log.size()) begin
                    n_err++; $display("FAIL %s start_missing[%0d]: starts=%0d need>%0d", name, j, start_log.size(), si);
                end else begin
                    if (start_log[si].c != acc_log[j].c + 1 || start_log[si].a !== a_exp) begin
                        n_err++; $display("FAIL %s start[%0d]: got cyc=%0d a=%0d need cyc=%0d a=%0d", name, j, start_log[si].c, start_log[si].a, acc_log[j].c + 1, a_exp);
                    end
                    n_cmp++;
                    if (rsp_log[j].c != start_log[si].c + LAT + 1) begin n_err++; $display("FAIL %s rsp_lat[%0d]: got %0d need %0d", name, j, rsp_log[j].c, start_log[si].c + LAT + 1); end
                    si++;
                end
                n_cmp++;
                if (rsp_log[j].data !== inv_ref(a_exp) || rsp_log[j].err !== 1'b0) begin n_err++; $display("FAIL %s rsp_data[%0d]: got data=%0d err=%b need %0d/0", name, j, rsp_log[j].data, rsp_log[j].err, inv_ref(a_exp)); end
            end
            if (j + 1 < n_acc) begin
                n_cmp++;
                if (acc_log[j+1].c != rsp_log[j].c + 1) begin n_err++; $display("FAIL %s back_to_back[%0d]: got %0d need %0d", name, j, acc_log[j+1].c, rsp_log[j].c + 1); end
            end
        end
        n_cmp++;
        if (start_log.size() != si) begin n_err++; $display("FAIL %s extra_start: got %0d need %0d", name, start_log.size(), si); end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = {8'd5, 8'd4, 8'd3, 8'd2};
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== '0 || inv_start !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: busy=%b ready=%b start=%b need 0", busy, req_ready, inv_start); end
        n_cmp++;
        if (inv_a !== '0 || rsp_data !== '0) begin n_err++; $display("FAIL reset_data: inv_a=%0h rsp_data=%0h need 0", inv_a, rsp_data); end
        n_cmp++;
        if (rsp_valid !== '0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp: valid=%b err=%b need 0", rsp_valid, rsp_err); end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        req_valid = '0;
        mdl_last  = NREQ - 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        run_batch("round_robin", 4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, 1'b1, 5);
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        drive_reqs(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0, 1, ok);
        wait_idle(ok);
        mdl_last = 0;
        n_cmp++;
        if (acc_log.size() != 1 || start_log.size() != 1 || rsp_log.size() != 1) begin
            n_err++; $display("FAIL single_count: acc=%0d start=%0d rsp=%0d need 1/1/1", acc_log.size(), start_log.size(), rsp_log.size());
        end else begin
            n_cmp++;
            if (acc_log[0].vec !== 4'b0001 || start_log[0].c != acc_log[0].c + 1 || start_log[0].a !== 8'd3) begin
                n_err++; $display("FAIL single_issue: grant=%b start_cyc=%0d a=%0d need 0001/%0d/3", acc_log[0].vec, start_log[0].c, start_log[0].a, acc_log[0].c + 1);
            end
            n_cmp++;
            if (rsp_log[0].vec !== 4'b0001 || rsp_log[0].data !== 9'd9 || rsp_log[0].err !== 1'b0 || rsp_log[0].c != start_log[0].c + LAT + 1) begin
                n_err++; $display("FAIL single_rsp: vec=%b data=%0d err=%b cyc=%0d need 0001/9/0/%0d", rsp_log[0].vec, rsp_log[0].data, rsp_log[0].err, rsp_log[0].c, start_log[0].c + LAT + 1);
            end
        end
    endtask

    task automatic test_zero();
        bit ok;
        clear_logs();
        drive_reqs(4'b0100, {8'd7, 8'd0, 8'd6, 8'd5}, 1'b0, 1, ok);
        wait_idle(ok);
        mdl_last = 2;
        n_cmp++;
        if (start_log.size() != 0) begin n_err++; $display("FAIL zero_start: starts=%0d need 0", start_log.size()); end
        n_cmp++;
        if (acc_log.size() != 1 || rsp_log.size() != 1) begin
            n_err++; $display("FAIL zero_count: acc=%0d rsp=%0d need 1/1", acc_log.size(), rsp_log.size());
        end else if (acc_log[0].vec !== 4'b0100 || rsp_log[0].vec !== 4'b0100 || rsp_log[0].c != acc_log[0].c + 1
                     || rsp_log[0].data !== '0 || rsp_log[0].err !== 1'b1) begin
            n_err++; $display("FAIL zero_rsp: grant=%b vec=%b cyc=%0d data=%0d err=%b need 0100/0100/%0d/0/1",
                              acc_log[0].vec, rsp_log[0].vec, rsp_log[0].c, rsp_log[0].data, rsp_log[0].err, acc_log[0].c + 1);
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        clear_logs();
        drive_reqs(4'b0001, {8'd0, 8'd0, 8'd7, 8'd3}, 1'b0, 1, ok);
        repeat (3) begin @(posedge clk); #1; end
        req_valid = 4'b0010;
        repeat (5) begin @(posedge clk); #1; end
        req_valid = '0;
        wait_idle(ok);
        repeat (5) @(negedge clk);
        mdl_last = 0;
        n_cmp++;
        if (acc_log.size() != 1) begin n_err++; $display("FAIL withdraw_accepts: got %0d need 1", acc_log.size()); end
        n_cmp++;
        if (rsp_log.size() != 1 || rsp_log[0].vec !== 4'b0001 || rsp_log[0].data !== 9'd9) begin
            n_err++; $display("FAIL withdraw_rsp: count=%0d need 1 with vec 0001 data 9", rsp_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g = 0;
        clear_logs();
        drive_reqs(4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 1'b0, 1, ok);
        while (start_log.size() == 0 && g < 50) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || start_log.size() != 1) begin n_err++; $display("FAIL midreset_wait: busy=%b starts=%0d need 1/1", busy, start_log.size()); end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n  = 1'b1;
        mdl_last = NREQ - 1;
        clear_logs();
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rsp_log.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_quiet: rsps=%0d busy=%b need 0/0", rsp_log.size(), busy); end
        run_batch("post_reset", 4'b1111, {8'd9, 8'd8, 8'd7, 8'd6}, 1'b1, 1);
    endtask

    task automatic test_random();
        logic [NREQ-1:0]       mask;
        logic [NREQ*WIDTH-1:0] ops;
        for (int r = 0; r < 6; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) ops[i*WIDTH +: WIDTH] = rand_op();
            run_batch($sformatf("random%0d", r), mask, ops, 1'b0, $countones(mask));
        end
    endtask

`ifdef INV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        mute = 1'b1;
        clear_logs();
        drive_reqs(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 1'b0, 1, ok);
        wait_idle(ok);
        mute = 1'b0;
        mdl_last = 0;
        n_cmp++;
        if (acc_log.size() != 1 || rsp_log.size() != 1) begin
            n_err++; $display("FAIL timeout_count: acc=%0d rsp=%0d need 1/1", acc_log.size(), rsp_log.size());
        end else if (rsp_log[0].c != acc_log[0].c + 1 + TOUT + 1 || rsp_log[0].data !== '0
                     || rsp_log[0].err !== 1'b1 || rsp_log[0].vec !== 4'b0001) begin
            n_err++; $display("FAIL timeout_rsp: cyc=%0d data=%0d err=%b vec=%b need %0d/0/1/0001",
                              rsp_log[0].c, rsp_log[0].data, rsp_log[0].err, rsp_log[0].vec, acc_log[0].c + TOUT + 2);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero();
        test_withdraw();
        test_reset_mid();
        test_random();
`ifdef INV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
